// File: rtl/module_controlador_memoria.sv
// Sequencing master for a 64x32 data memory: single reads/writes, one-cycle done pulse.
// Define CTRL_MEM_RMW_EN to perform byte-masked stores as read-modify-write.
module module_controlador_memoria #(
  parameter int WORDS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_req_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  localparam int IW = $clog2(WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_DONE
`ifdef CTRL_MEM_RMW_EN
    , S_RMW_RD, S_RMW_WR
`endif
  } state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
`ifdef CTRL_MEM_RMW_EN
  logic [3:0]      r_be;
  logic [31:0]     r_merge;
  logic [31:0]     w_merged;
`else
  logic            w_unused_be;
  assign w_unused_be = ^be_i;
`endif
  // Byte offset never selects a word.
  logic            w_unused_addr;
  assign w_unused_addr = ^addr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef CTRL_MEM_RMW_EN
      r_be    <= '0;
      r_merge <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_i) begin
        r_addr  <= addr_i[IW+1:2];
        r_wdata <= wdata_i;
`ifdef CTRL_MEM_RMW_EN
        r_be    <= be_i;
`endif
      end
      if (r_state == S_READ) r_rdata <= mem_rdata_i;
`ifdef CTRL_MEM_RMW_EN
      if (r_state == S_RMW_RD) r_merge <= mem_rdata_i;
`endif
    end
  end

`ifdef CTRL_MEM_RMW_EN
  always_comb begin
    w_merged = r_merge;
    for (int k = 0; k < 4; k++)
      if (r_be[k]) w_merged[8*k +: 8] = r_wdata[8*k +: 8];
  end
`endif

  always_comb begin
    w_next      = r_state;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    unique case (r_state)
      S_IDLE: begin
        if (req_i) begin
          if (!we_req_i) w_next = S_READ;
`ifdef CTRL_MEM_RMW_EN
          else if (be_i == 4'hF || be_i == 4'h0) w_next = S_WRITE;
          else w_next = S_RMW_RD;
`else
          else w_next = S_WRITE;
`endif
        end
      end
      S_READ: w_next = S_DONE;
      S_WRITE: begin
`ifdef CTRL_MEM_RMW_EN
        mem_we_o = (r_be != 4'h0);
`else
        mem_we_o = 1'b1;
`endif
        mem_wdata_o = r_wdata;
        w_next      = S_DONE;
      end
`ifdef CTRL_MEM_RMW_EN
      S_RMW_RD: w_next = S_RMW_WR;
      S_RMW_WR: begin
        mem_we_o    = 1'b1;
        mem_wdata_o = w_merged;
        w_next      = S_DONE;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign rdata_o    = r_rdata;
  assign done_o     = (r_state == S_DONE);
  assign busy_o     = (r_state != S_IDLE);
  assign mem_addr_o = 8'(r_addr);

endmodule
